usb_tx_line: RTL and testbench
==============================

Name: usb_tx_line

Overview:
Parametrised successor to the USB transmit bit stuffer. Takes a first-word-fall-through serial bit stream from the packet serializer and produces the full line sequence: optional SYNC prefix, bit stuffing with a configurable run limit, optional NRZI encoding, and a generated EOP (SE0 bits then J). Sits between the packet serializer/FIFO and the USB PHY output driver. Drives output-enable so the PHY tri-states between packets.

Parameters:
MAX_RUN, 6, number of consecutive 1 data bits after which a 0 is stuffed; range 1..15
SYNC_EN, 1, 1 = emit SYNC before the first data bit; 0 = upstream supplies SYNC
SYNC_LEN, 8, SYNC length in bits: SYNC_LEN-1 zeros followed by a single one (raw, pre-NRZI); range 2..32
EOP_SE0_BITS, 2, number of bit periods SE0 is driven at EOP; range 1..7
EOP_J_BITS, 1, number of bit periods J is driven after SE0; range 1..7
NRZI_EN, 1, 1 = NRZI encode; 0 = q carries the raw stuffed bit (test/bypass)

Ports:
c  in  1  clock; the block's single clock
rst  in  1  synchronous reset, active-high
d  in  1  next raw data bit; valid whenever d_empty=0
d_empty  in  1  upstream has no bit available
d_req  out  1  combinational pop strobe: the current d is consumed this cycle
q_req  in  1  bit-period strobe from the PHY timing generator; one line bit advances per strobe
q  out  1  line data bit (1=J, 0=K); meaningful when q_se0=0
q_se0  out  1  drive SE0 on the line
q_oe  out  1  line output enable
busy  out  1  state != IDLE

Behaviour:
- Reset (and at power-up through rst): state IDLE, q=1, q_se0=0, q_oe=0, busy=0, d_req=0, run counter=0, NRZI level=1 (J), SYNC/EOP counters=0. rst mid-packet aborts immediately: no EOP; q_oe=0 and q=1 on the cycle after rst.
- q, q_se0, q_oe are registered. Line bits change only in the cycle following a cycle with q_req=1; they hold between strobes.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE: if d_empty=0 -> SYNC (SYNC_EN=1) or DATA (SYNC_EN=0); q_oe rises the next cycle; no bit is emitted and d is not popped on the transition cycle.
- SYNC: on each q_req emit one raw bit (0 for SYNC_LEN-1 strobes, then 1); after the last strobe -> DATA. SYNC bits update the run counter (trailing 1 counts as run=1).
- DATA, on q_req: if d_empty=1 -> EOP_SE0, and the first SE0 bit is emitted on this strobe. Otherwise emit d, assert d_req this cycle; d=0 clears the run counter; d=1 increments it; on reaching MAX_RUN -> STUFF. d_req is never asserted without q_req or in any other state.
- STUFF, on q_req: emit raw 0, clear the run counter, -> DATA. The stuff bit is emitted even when d_empty=1; end-of-packet is then detected in DATA.
- d_empty is sampled only on q_req cycles; emptiness between strobes is ignored. Underrun inside a packet therefore ends the packet; keeping the FIFO fed is upstream's responsibility.
- NRZI (NRZI_EN=1): raw 0 toggles the level, raw 1 holds it; the level is reset to 1 on entering EOP_J and in IDLE.
- EOP_SE0: q_se0=1 for EOP_SE0_BITS strobes. EOP_J: q_se0=0, q=1 for EOP_J_BITS strobes. The last EOP_J strobe -> IDLE, and q_oe falls on the next cycle.
- In IDLE, q_req is ignored. A new packet may start on the cycle after returning to IDLE.
- Counter widths: run counter $clog2(MAX_RUN+1); SYNC/EOP counter 5 bits, wrap-free by the parameter ranges.

Decomposition:
- Package usb_tx_pkg: state encoding localparams, LINE_J=1/LINE_K=0 constants, state width.
- One sub-module, usb_nrzi_enc (inputs c, rst, adv, raw, force_j, bypass; output level), instantiated once.
- FSM and counters stay in usb_tx_line.

Test Plan:
- SYNC_EN=0, NRZI_EN=0, q_req every 4th cycle, feed bits 1×7 then empty -> line bits 1,1,1,1,1,1,0,1 then SE0,SE0,J; exactly 7 d_req pulses; q_oe high from the first bit to the cycle after the J strobe.
- NRZI_EN=1, SYNC_EN=0, bits 0,0,1,1,0 -> q=0,1,1,1,0 starting from J=1; EOP then q=1 with q_oe=0.
- Defaults, feed one bit 1 -> q=0,1,0,1,0,1,0,0 (SYNC), 0 (data), then SE0×2, J×1.
- Defaults, feed 5 ones after SYNC -> stuff 0 inserted after the 5th data one (run 6 includes the SYNC trailing one); no d_req on the stuff strobe.
- MAX_RUN=3, q_req held high every cycle, NRZI_EN=0, SYNC_EN=0, bits 1,1,1,1 -> 1,1,1,0,1, then EOP; d_req asserted exactly on the 4 data cycles.
- Assert rst for one cycle during DATA -> next cycle q_oe=0, q=1, q_se0=0, busy=0; no SE0 emitted; a new packet afterwards starts cleanly with a full SYNC.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared constants for the USB transmit line block.
// State encoding and line-level names used by the FSM and encoder.
package usb_tx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_SYNC    = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA    = 3'd2;
    localparam logic [STATE_W-1:0] S_STUFF   = 3'd3;
    localparam logic [STATE_W-1:0] S_EOP_SE0 = 3'd4;
    localparam logic [STATE_W-1:0] S_EOP_J   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = S_IDLE,
        ST_SYNC    = S_SYNC,
        ST_DATA    = S_DATA,
        ST_STUFF   = S_STUFF,
        ST_EOP_SE0 = S_EOP_SE0,
        ST_EOP_J   = S_EOP_J
    } state_e;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

endpackage

// File: rtl/usb_nrzi_enc.sv
// usb_nrzi_enc: NRZI level tracker for the transmit line.
// 'level' is the line value for the raw bit presented this cycle.
import usb_tx_pkg::*;

module usb_nrzi_enc (
    input  logic c,
    input  logic rst,
    input  logic adv,
    input  logic raw,
    input  logic force_j,
    input  logic bypass,
    output logic level
);

    logic level_q;
    logic level_d;
    logic nxt;

    // raw 0 toggles the line, raw 1 holds it
    always_comb begin
        nxt = raw ? level_q : ~level_q;
        level_d = level_q;
        if (force_j) begin
            level_d = LINE_J;
        end else if (adv) begin
            level_d = nxt;
        end
        level = bypass ? raw : nxt;
    end

    // current line level, idles at J
    always_ff @(posedge c) begin
        if (rst) begin
            level_q <= LINE_J;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/usb_tx_line.sv
// usb_tx_line: SYNC, bit stuffing, NRZI and EOP generation for the
// USB transmit path, paced by the PHY bit strobe q_req.
import usb_tx_pkg::*;

module usb_tx_line #(
    parameter int MAX_RUN      = 6,
    parameter bit SYNC_EN      = 1'b1,
    parameter int SYNC_LEN     = 8,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1,
    parameter bit NRZI_EN      = 1'b1
) (
    input  logic c,
    input  logic rst,
    input  logic d,
    input  logic d_empty,
    output logic d_req,
    input  logic q_req,
    output logic q,
    output logic q_se0,
    output logic q_oe,
    output logic busy
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W:0] RUN_MAX   = (RUN_W + 1)'(MAX_RUN);
    localparam logic [4:0]     SYNC_LAST = 5'(SYNC_LEN - 1);
    localparam logic [4:0]     SE0_N     = 5'(EOP_SE0_BITS);
    localparam logic [4:0]     J_N       = 5'(EOP_J_BITS);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W:0]   run_inc;
    logic [4:0]       cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             se0_q, se0_d;
    logic             oe_q, oe_d;
    logic             adv, raw, force_j, level;

    usb_nrzi_enc u_nrzi (
        .c       (c),
        .rst     (rst),
        .adv     (adv),
        .raw     (raw),
        .force_j (force_j),
        .bypass  (!NRZI_EN),
        .level   (level)
    );

    assign run_inc = {1'b0, run_q} + 1'b1;

    // next state, counters and line bit for the coming bit period
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        se0_d   = se0_q;
        oe_d    = oe_q;
        d_req   = 1'b0;
        adv     = 1'b0;
        raw     = LINE_J;
        force_j = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                force_j = 1'b1;
                q_d     = LINE_J;
                se0_d   = 1'b0;
                oe_d    = 1'b0;
                run_d   = '0;
                cnt_d   = '0;
                if (!d_empty) begin
                    state_d = SYNC_EN ? ST_SYNC : ST_DATA;
                    oe_d    = 1'b1;
                end
            end
            ST_SYNC: begin
                if (q_req) begin
                    raw = (cnt_q == SYNC_LAST);
                    adv = 1'b1;
                    q_d = level;
                    if (raw) begin
                        run_d   = RUN_W'(1);
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        run_d = '0;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (q_req) begin
                    if (d_empty) begin
                        se0_d   = 1'b1;
                        cnt_d   = 5'd1;
                        state_d = ST_EOP_SE0;
                    end else begin
                        d_req = 1'b1;
                        raw   = d;
                        adv   = 1'b1;
                        q_d   = level;
                        if (d) begin
                            run_d = run_inc[RUN_W-1:0];
                            if (run_inc >= RUN_MAX) begin
                                state_d = ST_STUFF;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end
            end
            ST_STUFF: begin
                if (q_req) begin
                    raw     = LINE_K;
                    adv     = 1'b1;
                    q_d     = level;
                    run_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_EOP_SE0: begin
                if (q_req) begin
                    if (cnt_q >= SE0_N) begin
                        se0_d   = 1'b0;
                        q_d     = LINE_J;
                        force_j = 1'b1;
                        cnt_d   = 5'd1;
                        state_d = ST_EOP_J;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (q_req) begin
                    if (cnt_q >= J_N) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, counters and registered line outputs
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
            q_q     <= LINE_J;
            se0_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            se0_q   <= se0_d;
            oe_q    <= oe_d;
        end
    end

    assign q     = q_q;
    assign q_se0 = se0_q;
    assign q_oe  = oe_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_line.sv
// tb_usb_tx_line: directed line-sequence bench for usb_tx_line.
// Three parameterisations: defaults, raw short-run, NRZI without SYNC.
module tb_usb_tx_line;

    logic c = 1'b0;
    logic rst;
    logic d_s  [3];
    logic e_s  [3];
    logic r_s  [3];
    logic dr_s [3];
    logic q_s  [3];
    logic se_s [3];
    logic oe_s [3];
    logic bz_s [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 c = ~c;

    usb_tx_line u_def (
        .c(c), .rst(rst), .d(d_s[0]), .d_empty(e_s[0]), .d_req(dr_s[0]),
        .q_req(r_s[0]), .q(q_s[0]), .q_se0(se_s[0]), .q_oe(oe_s[0]),
        .busy(bz_s[0])
    );

    usb_tx_line #(
        .MAX_RUN(3), .SYNC_EN(1'b0), .NRZI_EN(1'b0)
    ) u_raw (
        .c(c), .rst(rst), .d(d_s[1]), .d_empty(e_s[1]), .d_req(dr_s[1]),
        .q_req(r_s[1]), .q(q_s[1]), .q_se0(se_s[1]), .q_oe(oe_s[1]),
        .busy(bz_s[1])
    );

    usb_tx_line #(
        .SYNC_EN(1'b0), .EOP_SE0_BITS(1), .EOP_J_BITS(2)
    ) u_nz (
        .c(c), .rst(rst), .d(d_s[2]), .d_empty(e_s[2]), .d_req(dr_s[2]),
        .q_req(r_s[2]), .q(q_s[2]), .q_se0(se_s[2]), .q_oe(oe_s[2]),
        .busy(bz_s[2])
    );

    task automatic check(input string tag, input string got,
                         input string exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %s expected %s", tag, got, exp);
        end
    endtask

    function automatic string idle_str(input int u);
        return $sformatf("%b%b%b%b", q_s[u], oe_s[u], se_s[u], bz_s[u]);
    endfunction

    // feed bits, strobe every per cycles, log each emitted line symbol
    task automatic run_pkt(input int u, input int n, input logic [31:0] bits,
                           input int per, output string seq,
                           output int pops, output int bad, output bit done);
        int idx = 0;
        bit prevq = 0;
        bit prevbusy = 0;
        bit started = 0;
        logic [2:0] last;
        seq = "";
        pops = 0;
        bad = 0;
        done = 0;
        @(negedge c);
        last = {q_s[u], se_s[u], oe_s[u]};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) begin
                if (prevq && prevbusy && oe_s[u])
                    seq = {seq, se_s[u] ? "S" : (q_s[u] ? "1" : "0")};
                if (!prevq && prevbusy && {q_s[u], se_s[u], oe_s[u]} != last)
                    bad++;
                last = {q_s[u], se_s[u], oe_s[u]};
                if (started && !bz_s[u]) begin
                    done = 1;
                    break;
                end
            end
            if (bz_s[u]) started = 1;
            prevbusy = bz_s[u];
            e_s[u] = (idx >= n);
            d_s[u] = (idx < 32) ? bits[idx] : 1'b0;
            r_s[u] = ((cyc % per) == per - 1);
            #1;
            if (dr_s[u]) begin
                pops++;
                idx++;
                if (!r_s[u]) bad++;
            end
            prevq = r_s[u];
            @(negedge c);
        end
        r_s[u] = 1'b0;
        e_s[u] = 1'b1;
    endtask

    task automatic pkt(input string tag, input int u, input int n,
                       input logic [31:0] bits, input int per,
                       input string exp_seq, input int exp_pops);
        string seq;
        int pops, bad;
        bit done;
        run_pkt(u, n, bits, per, seq, pops, bad, done);
        check({tag, "_done"}, $sformatf("%0d", done), "1");
        check({tag, "_seq"}, seq, exp_seq);
        check({tag, "_pops"}, $sformatf("%0d", pops),
              $sformatf("%0d", exp_pops));
        check({tag, "_hold"}, $sformatf("%0d", bad), "0");
        check({tag, "_idle"}, idle_str(u), "1000");
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_s[i] = 1'b0;
            e_s[i] = 1'b1;
            r_s[i] = 1'b0;
        end
        repeat (3) @(negedge c);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d", i),
                  {idle_str(i), $sformatf("%b", dr_s[i])}, "10000");
        end
        rst = 1'b0;
        @(negedge c);

        pkt("raw7", 1, 7, 32'h7F, 4, "111011101SS1", 7);
        pkt("raw4", 1, 4, 32'h0F, 1, "11101SS1", 4);
        pkt("nrzi", 2, 5, 32'h0C, 3, "01110S11", 5);
        pkt("sync1", 0, 1, 32'h01, 2, "010101000SS1", 1);
        pkt("stuff5", 0, 5, 32'h1F, 2, "01010100000001SS1", 5);
        pkt("mix", 0, 3, 32'h05, 3, "01010100011SS1", 3);

        @(negedge c);
        e_s[0] = 1'b0;
        d_s[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            r_s[0] = (k % 2 == 1);
            @(negedge c);
        end
        r_s[0] = 1'b0;
        check("abort_busy", $sformatf("%b%b", bz_s[0], oe_s[0]), "11");
        rst = 1'b1;
        @(negedge c);
        rst = 1'b0;
        e_s[0] = 1'b1;
        check("abort_idle", idle_str(0), "1000");
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            r_s[0] = (k % 2 == 1);
            @(negedge c);
            if (oe_s[0] || se_s[0] || bz_s[0]) seen++;
        end
        r_s[0] = 1'b0;
        check("abort_quiet", $sformatf("%0d", seen), "0");
        pkt("resync", 0, 1, 32'h01, 2, "010101000SS1", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
